// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner and AXI-lite read master (AR/R) feeding decode.
// Optional perf counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_OUT
  } state_t;

  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [DATA_W-1:0] NOP_W   = DATA_W'(NOP_INST);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_pc;
  logic              r_pend;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_inst_err;

  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_drop;
  logic [ADDR_W-1:0] w_drop_pc;
  logic              w_leave_out;

  assign arvalid    = (r_state == S_AR);
  assign rready     = (r_state == S_R);
  assign inst_valid = (r_state == S_OUT);
  assign araddr     = r_pc;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_err   = r_inst_err;

  assign w_ar_hs = arvalid && arready;
  assign w_r_hs  = rvalid && rready;

  // A redirect arriving with the R beat counts as pending too;
  // the newest target wins.
  assign w_drop    = r_pend || redirect_valid;
  assign w_drop_pc = redirect_valid ? redirect_pc : r_pend_pc;

  assign w_leave_out = redirect_valid || inst_ready;

  // Fetch FSM, PC, pending redirect and held instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_RST;
      r_pend     <= 1'b0;
      r_pend_pc  <= PC_RST;
      r_inst     <= NOP_W;
      r_inst_pc  <= PC_RST;
      r_inst_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (redirect_valid) r_pc <= redirect_pc;
          r_state <= S_AR;
        end
        S_AR: begin
          if (redirect_valid) begin
            r_pend    <= 1'b1;
            r_pend_pc <= redirect_pc;
          end
          if (w_ar_hs) r_state <= S_R;
        end
        S_R: begin
          if (w_r_hs) begin
            if (w_drop) begin
              r_pc    <= w_drop_pc;
              r_pend  <= 1'b0;
              r_state <= S_AR;
            end else begin
              r_inst     <= rdata;
              r_inst_pc  <= r_pc;
              r_inst_err <= (rresp != 2'b00);
              r_state    <= S_OUT;
            end
          end else if (redirect_valid) begin
            r_pend    <= 1'b1;
            r_pend_pc <= redirect_pc;
          end
        end
        S_OUT: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end else if (inst_ready) begin
            r_pc <= r_pc + PC_STEP;
          end
          if (w_leave_out) begin
            r_inst     <= NOP_W;
            r_inst_err <= 1'b0;
            r_state    <= S_AR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Delivered-instruction and bus-wait cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (inst_valid && inst_ready)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (arvalid || rready)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
